// File: rtl/usb_transmitter_if.sv
// Handshake bundle between a TX FIFO/packet controller and the USB line encoder.
// The slave side is the encoder; the master side is whoever drives packets and watches the line.
interface usb_transmitter_if;
    logic       tx_start;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_r_enable;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;

    modport slave (
        input  tx_start, fifo_data, fifo_empty,
        output fifo_r_enable, d_plus, d_minus, tx_busy, tx_done
    );

    modport master (
        output tx_start, fifo_data, fifo_empty,
        input  fifo_r_enable, d_plus, d_minus, tx_busy, tx_done
    );
endinterface

// File: rtl/usb_transmitter.sv
// USB full-speed line encoder: SYNC, FIFO bytes LSB first with bit stuffing and NRZI, then EOP.
// level_reg always holds the line level of the bit currently on the wire.
module usb_transmitter #(
    parameter int         CLKS_PER_BIT = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'h80
) (
    input  logic           clk,
    input  logic           n_rst,
    usb_transmitter_if.slave tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      shift_reg, shift_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [CW-1:0]   clk_cnt_reg, clk_cnt_next;
    logic [2:0]      ones_reg, ones_next;
    logic            level_reg, level_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            stuff_last_reg, stuff_last_next;
    logic            ren;
    logic            send_en;
    logic            send_bit;
    logic            bit_end;

    assign bit_end = (clk_cnt_reg == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            clk_cnt_reg    <= '0;
            ones_reg       <= '0;
            level_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            stuff_last_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_idx_reg    <= bit_idx_next;
            clk_cnt_reg    <= clk_cnt_next;
            ones_reg       <= ones_next;
            level_reg      <= level_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            stuff_last_reg <= stuff_last_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_idx_next    = bit_idx_reg;
        clk_cnt_next    = clk_cnt_reg;
        ones_next       = ones_reg;
        level_next      = level_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        stuff_last_next = stuff_last_reg;
        ren             = 1'b0;
        send_en         = 1'b0;
        send_bit        = 1'b0;

        if (state_reg != IDLE)
            clk_cnt_next = bit_end ? '0 : clk_cnt_reg + CW'(1);

        case (state_reg)
            IDLE: begin
                if (tx.tx_start) begin
                    state_next   = SYNC;
                    busy_next    = 1'b1;
                    shift_next   = SYNC_BYTE;
                    bit_idx_next = '0;
                    clk_cnt_next = '0;
                    ones_next    = '0;
                    level_next   = 1'b1;
                    send_en      = 1'b1;
                    send_bit     = SYNC_BYTE[0];
                end
            end
            SYNC, DATA, STUFF: begin
                if (bit_end) begin
                    if (state_reg != STUFF && ones_reg == 3'd6) begin
                        // Stuff bit; the shift register is pre-advanced so STUFF never touches it.
                        state_next      = STUFF;
                        level_next      = ~level_reg;
                        ones_next       = '0;
                        stuff_last_next = (bit_idx_reg == 3'd7);
                        if (bit_idx_reg != 3'd7) begin
                            shift_next   = {1'b0, shift_reg[7:1]};
                            bit_idx_next = bit_idx_reg + 3'd1;
                        end
                    end else if ((state_reg != STUFF && bit_idx_reg == 3'd7) ||
                                 (state_reg == STUFF && stuff_last_reg)) begin
                        if (!tx.fifo_empty) begin
                            ren          = 1'b1;
                            state_next   = DATA;
                            shift_next   = tx.fifo_data;
                            bit_idx_next = '0;
                            send_en      = 1'b1;
                            send_bit     = tx.fifo_data[0];
                        end else begin
                            state_next   = EOP_SE0;
                            bit_idx_next = '0;
                        end
                    end else if (state_reg == STUFF) begin
                        state_next = DATA;
                        send_en    = 1'b1;
                        send_bit   = shift_reg[0];
                    end else begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                        send_en      = 1'b1;
                        send_bit     = shift_reg[1];
                    end
                end
            end
            EOP_SE0: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd1) begin
                        state_next   = EOP_J;
                        bit_idx_next = '0;
                        level_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (bit_end) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    ones_next  = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        // NRZI: a 0 toggles the line, a 1 holds it and extends the run of ones.
        if (send_en) begin
            level_next = send_bit ? level_next : ~level_next;
            ones_next  = send_bit ? ones_next + 3'd1 : 3'd0;
        end
    end

    assign tx.fifo_r_enable = ren;
    assign tx.d_plus        = (state_reg == EOP_SE0) ? 1'b0 : level_reg;
    assign tx.d_minus       = (state_reg == EOP_SE0) ? 1'b0 : ~level_reg;
    assign tx.tx_busy       = busy_reg;
    assign tx.tx_done       = done_reg;
endmodule

// File: tb/tb_usb_transmitter.sv
// Directed bench for usb_transmitter: line symbols per bit, busy length, pops and done pulse.
module tb_usb_transmitter;
    logic clk;
    logic n_rst;
    int   n_asrt;
    int   n_fail;
    logic [7:0] q[$];

    usb_transmitter_if bus ();

    usb_transmitter #(.CLKS_PER_BIT(8), .SYNC_BYTE(8'h80)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .tx    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_fifo();
        bus.fifo_empty = (q.size() == 0);
        bus.fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    function automatic logic [1:0] sym_of(input byte c);
        if (c == "J") return 2'b10;
        if (c == "K") return 2'b01;
        return 2'b00;
    endfunction

    // Runs one packet; exp is the per-bit line pattern (J/K/0, spaces ignored).
    // stray_at: cycle to pulse an ignored tx_start (-1 none); push_at: cycle to push a late byte.
    task automatic run_packet(input string name, input string exp, input int exp_ren,
                              input int stray_at, input int push_at);
        logic [1:0] syms[$];
        int nbits, busy_cnt, ren_cnt, done_cnt, budget;
        logic ren_s;
        for (int i = 0; i < exp.len(); i++)
            if (exp[i] != " ") syms.push_back(sym_of(exp[i]));
        nbits    = syms.size();
        budget   = nbits * 8 + 1;
        busy_cnt = 0;
        ren_cnt  = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.tx_start = 1'b1;
        @(posedge clk);
        #1 bus.tx_start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk({name, " first_bit_K"}, {30'd0, bus.d_plus, bus.d_minus}, 32'd1);
                chk({name, " busy_set"}, {31'd0, bus.tx_busy}, 32'd1);
            end
            if (c % 8 == 3 && c / 8 < nbits)
                chk($sformatf("%s bit%0d", name, c / 8), {30'd0, bus.d_plus, bus.d_minus},
                    {30'd0, syms[c / 8]});
            if (bus.tx_busy) busy_cnt++;
            if (bus.tx_done) done_cnt++;
            ren_s = bus.fifo_r_enable;
            if (ren_s) ren_cnt++;
            if (c == stray_at) bus.tx_start = 1'b1;
            @(posedge clk);
            #1;
            bus.tx_start = 1'b0;
            if (ren_s && q.size() != 0) void'(q.pop_front());
            if (c == push_at) q.push_back(8'h5A);
            upd_fifo();
        end
        chk({name, " busy_cycles"}, busy_cnt, nbits * 8);
        chk({name, " ren_count"}, ren_cnt, exp_ren);
        chk({name, " done_count"}, done_cnt, 1);
        chk({name, " idle_J"}, {30'd0, bus.d_plus, bus.d_minus}, 32'd2);
        $display("packet %s: %0d bits, busy %0d cycles, %0d pops", name, nbits, busy_cnt, ren_cnt);
    endtask

    initial begin
        int done_seen;
        n_asrt = 0;
        n_fail = 0;
        bus.tx_start = 1'b0;
        upd_fifo();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dp", {31'd0, bus.d_plus}, 32'd1);
        chk("reset_dm", {31'd0, bus.d_minus}, 32'd0);
        chk("reset_busy", {31'd0, bus.tx_busy}, 32'd0);
        chk("reset_done", {31'd0, bus.tx_done}, 32'd0);
        chk("reset_ren", {31'd0, bus.fifo_r_enable}, 32'd0);
        @(negedge clk) n_rst = 1'b1;

        // Reset asserted in the middle of SYNC aborts immediately to J.
        @(negedge clk) bus.tx_start = 1'b1;
        @(posedge clk);
        #1 bus.tx_start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("midsync_busy", {31'd0, bus.tx_busy}, 32'd1);
        n_rst = 1'b0;
        #1;
        chk("abort_line", {30'd0, bus.d_plus, bus.d_minus}, 32'd2);
        chk("abort_busy", {31'd0, bus.tx_busy}, 32'd0);
        @(negedge clk) n_rst = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.tx_done) done_seen++;
            if (bus.d_plus !== 1'b1 || bus.d_minus !== 1'b0) done_seen += 100;
        end
        chk("after_abort_quiet", done_seen, 0);
        $display("reset abort checked");

        q.push_back(8'h00);
        upd_fifo();
        run_packet("byte00", "KJKJKJKK JKJKJKJK 00J", 1, 40, -1);

        // Back to back: the next start is driven the cycle after tx_done.
        q.push_back(8'hFF);
        upd_fifo();
        run_packet("byteFF", "KJKJKJKK KKKKK J JJJ 00J", 1, -1, -1);

        q.push_back(8'hA5);
        q.push_back(8'h3C);
        upd_fifo();
        run_packet("A5_3C", "KJKJKJKK KJJKJJKK JKKKKKJK 00J", 2, 100, -1);

        q.push_back(8'hFC);
        upd_fifo();
        run_packet("byteFC_stuff_eop", "KJKJKJKK JKKKKKKK J 00J", 1, -1, -1);

        // Empty FIFO; a byte appearing during EOP must not be popped.
        run_packet("empty", "KJKJKJKK 00J", 0, -1, 66);
        chk("late_byte_kept", q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
